req_collector: RTL and testbench
================================

REQ_COLLECTOR -- requirements
Module: req_collector

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the request vector width.
REQ-002 Parameter NUM_BITS, default 3, SHALL set the index width; WIDTH SHALL equal 2**NUM_BITS.
REQ-003 Port clk, input, 1: the single clock; all state SHALL update on its rising edge.
REQ-004 Port rst_n, input, 1: reset, asynchronous, active-low.
REQ-005 Port reqIn, input, WIDTH: request pulses; bit i high at a rising edge SHALL raise request i.
REQ-006 Port maskIn, input, WIDTH: bit i high SHALL exclude pending bit i from arbitration.
REQ-007 Port ackIn, input, 1: consumer acknowledges the current grant.
REQ-008 Port grantValid, output, 1: a grant is presented.
REQ-009 Port grantNumber, output, NUM_BITS: index of the granted request, held stable while grantValid is high.
REQ-010 Port pendingVector, output, WIDTH: registered sticky pending bits.
REQ-011 Port lostCount, output, 4: saturating count of requests that arrive on an already-pending bit.

Function
REQ-012 At every edge, pending SHALL become pending | reqIn, minus any bit cleared by REQ-017.
REQ-013 Arbitration input SHALL be pending & ~maskIn; the highest set bit SHALL win (MSB priority).
REQ-014 FSM states SHALL be IDLE and GRANT; IDLE -> GRANT when the arbitration input is nonzero; GRANT -> IDLE on ackIn high.
REQ-015 On IDLE -> GRANT, grantNumber SHALL latch the winning index and grantValid SHALL go high.
REQ-016 Latency: request high at edge k -> pending bit visible after edge k -> grantValid high after edge k+1 (2 edges), when IDLE and unmasked.
REQ-017 On the ack edge in GRANT, pending[grantNumber] SHALL clear and grantValid SHALL drop; the next grant SHALL be issued no earlier than the following edge (one IDLE cycle minimum).
REQ-018 reqIn on bit grantNumber at the ack edge: set SHALL win; the bit SHALL stay pending.
REQ-019 ackIn in IDLE SHALL be ignored.
REQ-020 Changing maskIn during GRANT SHALL NOT revoke or alter the current grant.
REQ-021 The arbitration input equal to zero SHALL hold the FSM in IDLE, with grantValid low and grantNumber unchanged.
REQ-022 lostCount SHALL increment by the number of bits (0..WIDTH) in reqIn & pending at each edge, saturating at 15; a bit cleared by ack on the same edge SHALL NOT count as lost.
REQ-023 lostCount SHALL never wrap past 15.

Reset
REQ-024 rst_n low SHALL immediately force: FSM to IDLE, pending 0, grantValid 0, grantNumber 0, lostCount 0.
REQ-025 Reset asserted mid-GRANT SHALL drop the grant without an ack; requests present during reset SHALL be discarded.
REQ-026 The first request SHALL be sampled at the first rising edge after rst_n rises.

Structure
REQ-027 The shared package SHALL hold WIDTH/NUM_BITS defaults, the FSM state encoding (IDLE=0, GRANT=1), and the lostCount width and saturation constant.
REQ-028 Winner selection SHALL be one instance of the codebase's p_encoder_rec priority encoder (inVector = masked pending, outNumber = index); no other sub-modules.
REQ-029 The design SHALL be one always block for sequential state plus combinational next-state logic; there SHALL be no latches.

Verification
REQ-030 Reset, then reqIn=8'h01 for 1 cycle, ackIn held low -> grantValid=1, grantNumber=0 two edges later; it SHALL stay asserted indefinitely.
REQ-031 reqIn=8'h0F for 1 cycle, ack each grant on its first valid cycle -> grants in the order 3,2,1,0 with one IDLE cycle between them; pendingVector ends at 8'h00.
REQ-032 pending=8'h90, maskIn=8'h80 -> grantNumber=4; then clear the mask during GRANT -> grant stays 4; after ack, the next grant is 7.
REQ-033 reqIn=8'h04 every cycle for 20 cycles without ack -> lostCount saturates at 15; pendingVector=8'h04.
REQ-034 Ack the grant of bit 5 with reqIn=8'h20 on the same edge -> pendingVector[5] stays 1, lostCount unchanged, bit 5 re-granted after one IDLE cycle.
REQ-035 rst_n low mid-GRANT, asynchronously between edges -> grantValid, pendingVector and lostCount read 0 before the next edge.

Source files
------------

// File: rtl/req_collector_pkg.sv
// Shared defaults, FSM encoding and lost-counter constants for req_collector.
package req_collector_pkg;

  localparam int unsigned WIDTH_DEF    = 8;
  localparam int unsigned NUM_BITS_DEF = 3;

  localparam int unsigned    LOST_W   = 4;
  localparam logic [LOST_W-1:0] LOST_MAX = 4'd15;

  typedef enum logic {
    StIdle  = 1'b0,
    StGrant = 1'b1
  } state_e;

endpackage

// File: rtl/p_encoder_rec.sv
// Priority encoder: index of the highest set bit of inVector (0 when empty).
module p_encoder_rec #(
  parameter int unsigned NUM_BITS = 3,
  parameter int unsigned WIDTH    = 2 ** NUM_BITS
) (
  input  logic [WIDTH-1:0]    inVector,
  output logic [NUM_BITS-1:0] outNumber
);

  // Ascending scan, so the last (highest) set bit overwrites lower ones.
  always_comb begin
    outNumber = '0;
    for (int i = 0; i < int'(WIDTH); i++) begin
      if (inVector[i]) outNumber = NUM_BITS'(i);
    end
  end

endmodule

// File: rtl/req_collector.sv
// Collects request pulses into sticky pending bits and grants them one at a time,
// MSB first, with a saturating count of requests that hit an already-pending bit.
module req_collector
  import req_collector_pkg::*;
#(
  parameter int unsigned WIDTH    = WIDTH_DEF,
  parameter int unsigned NUM_BITS = NUM_BITS_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [WIDTH-1:0]    reqIn,
  input  logic [WIDTH-1:0]    maskIn,
  input  logic                ackIn,
  output logic                grantValid,
  output logic [NUM_BITS-1:0] grantNumber,
  output logic [WIDTH-1:0]    pendingVector,
  output logic [LOST_W-1:0]   lostCount
);

  state_e              state_q, state_d;
  logic [WIDTH-1:0]    pending_q, pending_d;
  logic [NUM_BITS-1:0] grant_q, grant_d;
  logic [LOST_W-1:0]   lost_q, lost_d;

  logic [WIDTH-1:0]    arb_vec;
  logic [WIDTH-1:0]    ack_clr;
  logic [WIDTH-1:0]    lost_bits;
  logic [NUM_BITS-1:0] winner;

  assign arb_vec = pending_q & ~maskIn;

  p_encoder_rec #(
    .NUM_BITS (NUM_BITS),
    .WIDTH    (WIDTH)
  ) u_enc (
    .inVector  (arb_vec),
    .outNumber (winner)
  );

  // Pending update, lost counting and FSM next state.
  always_comb begin
    logic [31:0] lost_sum;
    state_d = state_q;
    grant_d = grant_q;
    ack_clr = '0;
    if (state_q == StGrant && ackIn) ack_clr[grant_q] = 1'b1;

    // A new request on the bit being acked re-arms it and is not lost.
    pending_d = (pending_q & ~ack_clr) | reqIn;
    lost_bits = reqIn & pending_q & ~ack_clr;

    lost_sum = 32'(lost_q);
    for (int i = 0; i < int'(WIDTH); i++) begin
      lost_sum = lost_sum + 32'(lost_bits[i]);
    end
    lost_d = (lost_sum > 32'(LOST_MAX)) ? LOST_MAX : lost_sum[LOST_W-1:0];

    unique case (state_q)
      StIdle: begin
        if (|arb_vec) begin
          state_d = StGrant;
          grant_d = winner;
        end
      end
      StGrant: begin
        if (ackIn) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // All state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      pending_q <= '0;
      grant_q   <= '0;
      lost_q    <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      lost_q    <= lost_d;
    end
  end

  assign grantValid    = (state_q == StGrant);
  assign grantNumber   = grant_q;
  assign pendingVector = pending_q;
  assign lostCount     = lost_q;

endmodule

// File: tb/tb_req_collector.sv
// Self-checking bench for req_collector: direct checks plus a grant-order scoreboard.
module tb_req_collector;

  logic       clk;
  logic       rst_n;
  logic [7:0] reqIn;
  logic [7:0] maskIn;
  logic       ackIn;
  logic       grantValid;
  logic [2:0] grantNumber;
  logic [7:0] pendingVector;
  logic [3:0] lostCount;

  int n_tests;
  int n_fail;
  int exp_q[$];
  logic prev_v;

  req_collector #(
    .WIDTH    (8),
    .NUM_BITS (3)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .reqIn         (reqIn),
    .maskIn        (maskIn),
    .ackIn         (ackIn),
    .grantValid    (grantValid),
    .grantNumber   (grantNumber),
    .pendingVector (pendingVector),
    .lostCount     (lostCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_grant(input string tag);
    int n = 0;
    while (!grantValid && n < 8) begin
      tick();
      n++;
    end
    if (!grantValid) check(tag, 32'(grantValid), 1);
  endtask

  task automatic ack_once();
    ackIn = 1'b1;
    tick();
    ackIn = 1'b0;
  endtask

  // Scoreboard: every new grant must match the oldest expected index.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_v <= 1'b0;
    end else begin
      if (grantValid && !prev_v) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_grant", 32'(grantNumber), 999);
        end else begin
          check("sb_grant_order", 32'(grantNumber), 32'(exp_q.pop_front()));
        end
      end
      prev_v <= grantValid;
    end
  end

  initial begin
    n_tests = 0;
    n_fail  = 0;
    rst_n   = 1'b0;
    reqIn   = 8'hFF;
    maskIn  = 8'h00;
    ackIn   = 1'b0;

    // Reset state; requests during reset are discarded.
    tick();
    tick();
    check("rst_valid", 32'(grantValid), 0);
    check("rst_pending", 32'(pendingVector), 0);
    check("rst_number", 32'(grantNumber), 0);
    check("rst_lost", 32'(lostCount), 0);
    reqIn = 8'h00;
    rst_n = 1'b1;
    tick();
    check("post_rst_pending", 32'(pendingVector), 0);

    // Single request: pending after one edge, grant after two, held without ack.
    exp_q.push_back(0);
    reqIn = 8'h01;
    tick();
    reqIn = 8'h00;
    check("lat_pending", 32'(pendingVector), 32'h01);
    check("lat_valid_early", 32'(grantValid), 0);
    tick();
    check("lat_valid", 32'(grantValid), 1);
    check("lat_number", 32'(grantNumber), 0);
    repeat (6) tick();
    check("hold_valid", 32'(grantValid), 1);
    ack_once();
    check("ack_drop", 32'(grantValid), 0);
    check("ack_clear", 32'(pendingVector), 0);
    // Ack in idle is ignored.
    ack_once();
    check("idle_ack", 32'(grantValid), 0);

    // Four requests granted MSB first with an idle cycle between.
    for (int i = 3; i >= 0; i--) exp_q.push_back(i);
    reqIn = 8'h0F;
    tick();
    reqIn = 8'h00;
    wait_grant("seq_first");
    for (int i = 0; i < 4; i++) begin
      ack_once();
      check("seq_gap", 32'(grantValid), 0);
      if (i < 3) begin
        tick();
        check("seq_next", 32'(grantValid), 1);
      end
    end
    check("seq_pending", 32'(pendingVector), 0);

    // Mask selects bit 4; unmasking mid-grant must not disturb it; then 7.
    maskIn = 8'hFF;
    reqIn  = 8'h90;
    tick();
    reqIn  = 8'h00;
    check("mask_pending", 32'(pendingVector), 32'h90);
    check("mask_no_grant", 32'(grantValid), 0);
    exp_q.push_back(4);
    maskIn = 8'h80;
    tick();
    check("mask_number", 32'(grantNumber), 4);
    maskIn = 8'h00;
    tick();
    check("mask_hold_valid", 32'(grantValid), 1);
    check("mask_hold_number", 32'(grantNumber), 4);
    exp_q.push_back(7);
    ack_once();
    check("mask_gap", 32'(grantValid), 0);
    tick();
    check("mask_next", 32'(grantNumber), 7);
    ack_once();
    check("mask_pending_end", 32'(pendingVector), 0);

    // Re-request on the acked bit: stays pending, not lost, re-granted.
    exp_q.push_back(5);
    exp_q.push_back(5);
    reqIn = 8'h20;
    tick();
    reqIn = 8'h00;
    wait_grant("rereq_first");
    ackIn = 1'b1;
    reqIn = 8'h20;
    tick();
    ackIn = 1'b0;
    reqIn = 8'h00;
    check("rereq_pending", 32'(pendingVector), 32'h20);
    check("rereq_lost", 32'(lostCount), 0);
    check("rereq_gap", 32'(grantValid), 0);
    tick();
    check("rereq_valid", 32'(grantValid), 1);
    check("rereq_number", 32'(grantNumber), 5);
    ack_once();

    // Repeated request on one bit: lost count climbs then saturates.
    exp_q.push_back(2);
    reqIn = 8'h04;
    repeat (5) tick();
    check("lost_mid", 32'(lostCount), 4);
    repeat (15) tick();
    reqIn = 8'h00;
    check("lost_sat", 32'(lostCount), 15);
    check("lost_pending", 32'(pendingVector), 32'h04);

    // Asynchronous reset mid-grant clears everything before the next edge.
    check("pre_rst_valid", 32'(grantValid), 1);
    #2;
    rst_n = 1'b0;
    reqIn = 8'hFF;
    #1;
    check("arst_valid", 32'(grantValid), 0);
    check("arst_pending", 32'(pendingVector), 0);
    check("arst_lost", 32'(lostCount), 0);
    check("arst_number", 32'(grantNumber), 0);
    tick();

    // First request after release is taken at the first edge.
    rst_n = 1'b1;
    reqIn = 8'h02;
    maskIn = 8'hFF;
    tick();
    check("first_req", 32'(pendingVector), 32'h02);

    // Two simultaneous lost requests add two.
    reqIn = 8'h03;
    tick();
    check("multi_lost0", 32'(lostCount), 1);
    tick();
    reqIn = 8'h00;
    check("multi_lost1", 32'(lostCount), 3);
    check("masked_idle", 32'(grantValid), 0);

    check("sb_empty", 32'(exp_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
